// File: rtl/amp_config_sequencer.sv
// Walks the amplifier register table and writes each entry over the shared I2C master,
// retrying NACKed entries. Define AMP_CFG_READBACK_EN to verify every write with a readback.
module amp_config_sequencer #(
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned IDX_W      = 3,
  parameter logic [6:0]  DEV_ADDR   = 7'h2C,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned GAP_CYCLES = 100
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             send_config,
  input  logic             abort,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [7:0]       tbl_reg,
  input  logic [7:0]       tbl_val,
  output logic             i2c_req,
  output logic [6:0]       i2c_dev,
  output logic [7:0]       i2c_reg,
  output logic [7:0]       i2c_wdata,
  input  logic             i2c_done,
  input  logic             i2c_nack,
`ifdef AMP_CFG_READBACK_EN
  output logic             i2c_rnw,
  input  logic [7:0]       i2c_rdata,
`endif
  output logic             busy,
  output logic             config_done,
  output logic             config_error,
  output logic [IDX_W-1:0] err_idx
);

  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned GapW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [IDX_W-1:0]  LastIdx  = IDX_W'(NUM_REGS - 1);
  localparam logic [RetryW-1:0] MaxRetry = RetryW'(MAX_RETRY);
  localparam logic [GapW-1:0]   GapLast  = GapW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StReq, StWait, StGap, StDone, StError
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  err_idx_q, err_idx_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              pending_q, pending_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              req_q, req_d;
  logic              rd_phase_q, rd_phase_d;
  logic [6:0]        dev_q, dev_d;
  logic [7:0]        reg_q, reg_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              xfer_ok;

`ifdef AMP_CFG_READBACK_EN
  localparam bit ReadbackEn = 1'b1;
  // A readback counts as good only if it ACKs and returns what was written.
  assign xfer_ok = !i2c_nack && (!rd_phase_q || (i2c_rdata == wdata_q));
  assign i2c_rnw = rd_phase_q;
`else
  localparam bit ReadbackEn = 1'b0;
  assign xfer_ok = !i2c_nack;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    err_idx_d  = err_idx_q;
    retry_d    = retry_q;
    gap_d      = gap_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    req_d      = req_q;
    rd_phase_d = rd_phase_q;
    dev_d      = dev_q;
    reg_d      = reg_q;
    wdata_d    = wdata_q;
    pending_d  = pending_q | (send_config & (state_q != StIdle));

    unique case (state_q)
      StIdle: begin
        if (send_config && !abort) begin
          state_d    = StLoad;
          idx_d      = '0;
          retry_d    = '0;
          rd_phase_d = 1'b0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_idx_d  = '0;
          busy_d     = 1'b1;
          pending_d  = 1'b0;
        end
      end
      StLoad: begin
        reg_d   = tbl_reg;
        wdata_d = tbl_val;
        dev_d   = DEV_ADDR;
        state_d = StReq;
      end
      StReq: begin
        req_d   = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        // Only WAIT holds i2c_req, so done pulses anywhere else are ignored.
        if (i2c_done) begin
          req_d = 1'b0;
          if (abort) begin
            state_d    = StIdle;
            busy_d     = 1'b0;
            pending_d  = 1'b0;
            retry_d    = '0;
            rd_phase_d = 1'b0;
          end else if (xfer_ok) begin
            if (ReadbackEn && !rd_phase_q) begin
              rd_phase_d = 1'b1;
              state_d    = StGap;
            end else begin
              rd_phase_d = 1'b0;
              retry_d    = '0;
              if (idx_q == LastIdx) begin
                state_d = StDone;
              end else begin
                idx_d   = idx_q + 1'b1;
                state_d = StGap;
              end
            end
          end else begin
            rd_phase_d = 1'b0;
            if (retry_q < MaxRetry) begin
              retry_d = retry_q + 1'b1;
              state_d = StGap;
            end else begin
              state_d = StError;
            end
          end
        end
      end
      StGap: begin
        if (abort) begin
          state_d    = StIdle;
          busy_d     = 1'b0;
          pending_d  = 1'b0;
          gap_d      = '0;
          retry_d    = '0;
          rd_phase_d = 1'b0;
        end else if (gap_q == GapLast) begin
          gap_d   = '0;
          state_d = StLoad;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StDone, StError: begin
        if (state_q == StDone) begin
          done_d  = 1'b1;
          error_d = 1'b0;
        end else begin
          error_d   = 1'b1;
          done_d    = 1'b0;
          err_idx_d = idx_q;
        end
        // A start request seen while busy replays the whole table.
        pending_d = 1'b0;
        if (pending_q || send_config) begin
          state_d = StLoad;
          idx_d   = '0;
          retry_d = '0;
        end else begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      err_idx_q  <= '0;
      retry_q    <= '0;
      gap_q      <= '0;
      pending_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      req_q      <= 1'b0;
      rd_phase_q <= 1'b0;
      dev_q      <= '0;
      reg_q      <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      err_idx_q  <= err_idx_d;
      retry_q    <= retry_d;
      gap_q      <= gap_d;
      pending_q  <= pending_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      req_q      <= req_d;
      rd_phase_q <= rd_phase_d;
      dev_q      <= dev_d;
      reg_q      <= reg_d;
      wdata_q    <= wdata_d;
    end
  end

  assign tbl_idx      = idx_q;
  assign i2c_req      = req_q;
  assign i2c_dev      = dev_q;
  assign i2c_reg      = reg_q;
  assign i2c_wdata    = wdata_q;
  assign busy         = busy_q;
  assign config_done  = done_q;
  assign config_error = error_q;
  assign err_idx      = err_idx_q;

endmodule

// File: doc/amp_config_sequencer.md
Name: amp_config_sequencer

Overview:
- Sequences the amplifier register configuration whenever the amp state controller pulses send_config.
- Walks a NUM_REGS-entry register table (external ROM/regfile, addressed by tbl_idx) and issues one I2C register write per entry to the shared I2C master through a req/done handshake.
- Retries NACKed writes and reports busy/done/error back to the amp state controller.

Parameters:
- NUM_REGS, 8, number of table entries to write (1..255).
- IDX_W, 3, width of tbl_idx; must satisfy 2^IDX_W >= NUM_REGS.
- DEV_ADDR, 7'h2C, 7-bit I2C device address of the amplifier.
- MAX_RETRY, 3, retries per entry after the first NACK.
- GAP_CYCLES, 100, idle clk cycles between consecutive I2C transactions, including before a retry.

Ports:
- clk  input  1  system clock (100 MHz)
- nreset  input  1  asynchronous active-low reset
- send_config  input  1  one-cycle start pulse from the amp state controller
- abort  input  1  level; cancels the sequence at the next safe point
- tbl_idx  output  IDX_W  table read index
- tbl_reg  input  8  register address at tbl_idx; combinational, valid in the same cycle
- tbl_val  input  8  register value at tbl_idx; combinational, valid in the same cycle
- i2c_req  output  1  transaction request, held high until done
- i2c_dev  output  7  device address, always DEV_ADDR
- i2c_reg  output  8  register address, stable while i2c_req=1
- i2c_wdata  output  8  write data, stable while i2c_req=1
- i2c_done  input  1  one-cycle completion pulse from the I2C master
- i2c_nack  input  1  qualifies i2c_done; 1 means the transaction failed
- busy  output  1  high from the cycle after send_config until DONE/ERROR/IDLE
- config_done  output  1  sticky success flag
- config_error  output  1  sticky failure flag
- err_idx  output  IDX_W  index of the failing entry, valid while config_error=1

Behaviour:
- Reset (nreset=0, asynchronous) forces:
  - all outputs to 0;
  - state to IDLE, index=0, retry counter=0, gap counter=0, pending=0.
- States and transitions:
  - IDLE: on send_config -> LOAD. Clear config_done, config_error, err_idx and the retry counter.
  - LOAD (1 cycle): capture tbl_reg/tbl_val into i2c_reg/i2c_wdata -> REQ.
  - REQ: assert i2c_req -> WAIT.
  - WAIT: i2c_req stays 1. On i2c_done:
    - ack: clear retries. If abort -> IDLE. Else if idx=NUM_REGS-1 -> DONE. Else idx+1 and -> GAP.
    - nack: if abort -> IDLE. Else if retries<MAX_RETRY then retries+1 and -> GAP (same idx). Else -> ERROR.
  - GAP: count GAP_CYCLES cycles -> LOAD. abort in GAP -> IDLE immediately.
  - DONE: config_done=1 -> IDLE.
  - ERROR: config_error=1, err_idx=idx -> IDLE.
- i2c_req deasserts in the cycle after i2c_done. abort never drops i2c_req mid-transaction.
- The I2C master must not assert i2c_done while i2c_req=0. Any such pulse is ignored.
- send_config while busy: latched into pending. On reaching DONE or ERROR, pending restarts the sequence at LOAD with idx=0 and clears pending. Abort also clears pending.
- Simultaneous send_config and abort in IDLE: abort wins and no start occurs.
- Latency: send_config at cycle 0 -> i2c_req=1 at cycle 3 (IDLE->LOAD->REQ).
- Counters saturate and never wrap. idx is compared against NUM_REGS-1, so a power-of-2 NUM_REGS never wraps to 0.
- config_done and config_error are never 1 at the same time.

Optional Feature:
- Macro: AMP_CFG_READBACK_EN.
- With the macro defined, two ports are added:
  - i2c_rnw, output, 1 bit;
  - i2c_rdata, input, 8 bits, valid with i2c_done.
- After each acked write, the block waits GAP_CYCLES and then issues a read of the same register (i2c_rnw=1).
- A read that NACKs, or returns data not equal to tbl_val, is treated as a NACK of that entry. The retry restarts from the write.
- Without the macro: i2c_rnw and i2c_rdata do not exist, and every transaction is a write.

Test Plan:
- Nominal run: NUM_REGS=8, master always acks after 20 cycles, send_config pulse. Required:
  - exactly 8 transactions with i2c_reg/i2c_wdata matching table entries 0..7;
  - config_done=1 and busy=0 after the last ack;
  - first i2c_req at cycle 3.
- Single retry: entry 2 NACKs once. Required:
  - entry 2 is reissued after 100 gap cycles;
  - 9 transactions total;
  - config_done=1, config_error=0.
- Retry exhaustion: entry 5 always NACKs with MAX_RETRY=3. Required:
  - exactly 4 attempts on entry 5;
  - config_error=1, err_idx=5, config_done=0;
  - no request issued for entry 6.
- Abort: abort asserted during WAIT of entry 3. Required:
  - i2c_req held until i2c_done;
  - state returns to IDLE, busy=0;
  - no further requests;
  - flags stay 0.
- Restart while busy: a second send_config at entry 4. Required:
  - first pass completes;
  - sequence restarts at idx 0;
  - 16 transactions total, ending with config_done=1.
- Async reset in WAIT: nreset pulled low for 1 ns mid-transaction. Required:
  - i2c_req=0 and busy=0 immediately, without waiting for a clk edge;
  - a later send_config restarts from idx 0.
